digit_composer: RTL and testbench

Sequential BCD-to-binary converter: the inverse of the FND path's binary-to-digit split. It takes four BCD digits (ones, tens, hundreds, thousands) on a start strobe and produces the 14-bit binary value 0–9999 after a fixed multi-cycle accumulation. It sits on the input side of the FND controller, turning keypad/register-entered decimal digits back into a binary count. It flags any non-decimal digit.

---
 rtl/digit_composer.sv | 149 ++++++++++++++
 tb/tb_digit_composer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/digit_composer.sv
// Sequential BCD-to-binary converter: folds four captured BCD digits into a
// 14-bit binary value by repeated acc*10 + digit, most significant digit first.
module digit_composer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_clear,
    input  logic [3:0]  i_1_value,
    input  logic [3:0]  i_10_value,
    input  logic [3:0]  i_100_value,
    input  logic [3:0]  i_1000_value,
    output logic [13:0] o_value,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int DIGIT_W = 4;
    localparam int VALUE_W = 14;
    localparam int STEPS   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 start_cap;

    logic [DIGIT_W-1:0]   digit_q [STEPS];
    logic [1:0]           step_q;
    logic [VALUE_W-1:0]   acc_q;
    logic                 err_q;

    logic [DIGIT_W-1:0]   cur_digit;
    logic [VALUE_W-1:0]   acc_next;
    logic                 err_next;
    logic                 last_step;

    logic [VALUE_W-1:0]   value_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 error_q;

    // Multiply-by-ten built from two shifts; wraps modulo 2^14 on bad digits.
    function automatic logic [VALUE_W-1:0] mac10(input logic [VALUE_W-1:0] acc,
                                                 input logic [DIGIT_W-1:0] digit);
        logic [VALUE_W-1:0] ext;
        ext = {{(VALUE_W-DIGIT_W){1'b0}}, digit};
        return (acc << 3) + (acc << 1) + ext;
    endfunction

    function automatic logic is_bad_digit(input logic [DIGIT_W-1:0] digit);
        return digit > 4'd9;
    endfunction

    assign cur_digit = digit_q[step_q];
    assign acc_next  = mac10(acc_q, cur_digit);
    assign err_next  = err_q | is_bad_digit(cur_digit);
    assign last_step = (step_q == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        start_cap = 1'b0;
        if (i_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_d   = ACC;
                        start_cap = 1'b1;
                    end
                end
                ACC: begin
                    if (last_step) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    if (i_start) begin
                        state_d   = ACC;
                        start_cap = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Digit capture and accumulation; digit_q[0] holds the thousands digit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < STEPS; i++) begin
                digit_q[i] <= '0;
            end
            step_q <= '0;
            acc_q  <= '0;
            err_q  <= 1'b0;
        end else if (start_cap) begin
            digit_q[0] <= i_1000_value;
            digit_q[1] <= i_100_value;
            digit_q[2] <= i_10_value;
            digit_q[3] <= i_1_value;
            step_q     <= '0;
            acc_q      <= '0;
            err_q      <= 1'b0;
        end else if (state_q == ACC && !i_clear) begin
            step_q <= step_q + 2'd1;
            acc_q  <= acc_next;
            err_q  <= err_next;
        end
    end

    // Registered outputs, derived from the next state so busy/done never overlap.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            value_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            busy_q <= (state_d == ACC);
            done_q <= (state_d == DONE);
            if (state_q == ACC && last_step) begin
                value_q <= err_next ? '0 : acc_next;
                error_q <= err_next;
            end
        end
    end

    assign o_value = value_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_error = error_q;

endmodule

// File: tb/tb_digit_composer.sv
// Directed bench for digit_composer: hand-computed conversions, reset/clear
// behaviour, back-to-back starts and digit-change immunity during accumulation.
module tb_digit_composer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        clear;
    logic [3:0]  d1, d10, d100, d1000;
    logic [13:0] value;
    logic        busy;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;
    logic [13:0] last_val = '0;

    digit_composer dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_clear      (clear),
        .i_1_value    (d1),
        .i_10_value   (d10),
        .i_100_value  (d100),
        .i_1000_value (d1000),
        .o_value      (value),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [3:0] th, input logic [3:0] hu,
                              input logic [3:0] te, input logic [3:0] on);
        d1000 = th;
        d100  = hu;
        d10   = te;
        d1    = on;
    endtask

    task automatic convert(input string tag, input logic [3:0] th, input logic [3:0] hu,
                           input logic [3:0] te, input logic [3:0] on,
                           input logic [13:0] exp_val, input logic exp_err);
        set_digits(th, hu, te, on);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq({tag, "_busy"}, busy, 1'b1);
            check_eq({tag, "_nodone"}, done, 1'b0);
            check_eq({tag, "_hold"}, value, last_val);
            if (k < 3) step_clk();
        end
        step_clk();
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_idle"}, busy, 1'b0);
        check_eq({tag, "_value"}, value, exp_val);
        check_eq({tag, "_error"}, error, exp_err);
        last_val = exp_val;
        step_clk();
        check_eq({tag, "_done_drop"}, done, 1'b0);
        check_eq({tag, "_value_kept"}, value, exp_val);
        check_eq({tag, "_error_kept"}, error, exp_err);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        step_clk();
        step_clk();
        check_eq("rst_value", value, 14'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_error", error, 1'b0);
        rst = 1'b0;
        step_clk();

        convert("basic1234", 4'd1, 4'd2, 4'd3, 4'd4, 14'd1234, 1'b0);
        convert("all9", 4'd9, 4'd9, 4'd9, 4'd9, 14'h270F, 1'b0);
        convert("all0", 4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0);
        convert("ones7", 4'd0, 4'd0, 4'd0, 4'd7, 14'd7, 1'b0);
        convert("digits0042a", 4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0);
        convert("bad_tens", 4'd1, 4'd2, 4'hC, 4'd4, 14'd0, 1'b1);
        convert("after_bad", 4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0);
        convert("bad_thou", 4'hF, 4'd0, 4'd0, 4'd1, 14'd0, 1'b1);
        convert("mixed8051", 4'd8, 4'd0, 4'd5, 4'd1, 14'd8051, 1'b0);

        // Reset two cycles into a conversion.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        check_eq("midrst_value", value, 14'd0);
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_done", done, 1'b0);
        check_eq("midrst_error", error, 1'b0);
        last_val = '0;
        for (int k = 0; k < 5; k++) begin
            step_clk();
            check_eq("midrst_quiet_done", done, 1'b0);
            check_eq("midrst_quiet_busy", busy, 1'b0);
        end
        convert("post_rst0987", 4'd0, 4'd9, 4'd8, 4'd7, 14'd987, 1'b0);

        // Start held high: back-to-back conversions; digits changed mid-flight.
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        start = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c == 6) set_digits(4'd1, 4'd1, 4'd1, 4'd1);
            if (c == 12) start = 1'b0;
            step_clk();
            check_eq("b2b_done", done, (c == 4 || c == 9 || c == 14));
            check_eq("b2b_busy", busy, (c <= 3) || (c >= 5 && c <= 8) || (c >= 10 && c <= 13));
            if (c == 4 || c == 9) check_eq("b2b_value5678", value, 14'd5678);
            if (c == 14) check_eq("b2b_value1111", value, 14'd1111);
        end
        last_val = 14'd1111;

        // Clear during step 2 discards the conversion.
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        start = 1'b1;
        step_clk();
        start = 1'b0;
        step_clk();
        step_clk();
        clear = 1'b1;
        step_clk();
        clear = 1'b0;
        check_eq("clr_busy", busy, 1'b0);
        check_eq("clr_done", done, 1'b0);
        check_eq("clr_value", value, 14'd0);
        for (int k = 0; k < 5; k++) begin
            step_clk();
            check_eq("clr_quiet_done", done, 1'b0);
            check_eq("clr_quiet_value", value, 14'd0);
        end
        last_val = '0;

        // Clear together with start in IDLE: nothing starts, error flag cleared.
        convert("pre_clr_bad", 4'd1, 4'hA, 4'd0, 4'd0, 14'd0, 1'b1);
        set_digits(4'd3, 4'd3, 4'd3, 4'd3);
        start = 1'b1;
        clear = 1'b1;
        step_clk();
        start = 1'b0;
        clear = 1'b0;
        check_eq("clrstart_busy", busy, 1'b0);
        check_eq("clrstart_error", error, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step_clk();
            check_eq("clrstart_quiet_done", done, 1'b0);
            check_eq("clrstart_quiet_busy", busy, 1'b0);
        end
        convert("final3333", 4'd3, 4'd3, 4'd3, 4'd3, 14'd3333, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
